// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// State encoding doubles as the occupancy count reported on o_occ.
package pipe_stage_pkg;

  localparam int OCC_W = 2;

  // Building block for the default "safe" control value (all control bits deasserted).
  localparam logic CTRL_SAFE_BIT = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One data+control holding register with load enable and a synchronous
// clear that forces only the control field to its safe value.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                CTRL_W    = 8,
  parameter logic [CTRL_W-1:0] CTRL_SAFE = {CTRL_W{CTRL_SAFE_BIT}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clear beats load so a discarded entry can never leave live control bits behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= {DATA_W{1'b0}};
      ctrl_q <= CTRL_SAFE;
    end else if (clr_i) begin
      data_q <= data_q;
      ctrl_q <= CTRL_SAFE;
    end else if (ld_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end else begin
      data_q <= data_q;
      ctrl_q <= ctrl_q;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall and flush; control is forced safe when empty.
// Define PIPE_STAGE_SKID_EN to add a skid slot that removes the i_ready->o_ready path.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                CTRL_W    = 8,
  parameter logic [CTRL_W-1:0] CTRL_SAFE = {CTRL_W{CTRL_SAFE_BIT}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  input  logic              i_flush,
  output logic [OCC_W-1:0]  o_occ
);

  state_e            state_q;
  state_e            state_d;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              ld_main_s;
  logic              clr_main_s;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
  logic              ld_skid_s;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
`endif

  assign o_valid = (state_q != ST_EMPTY);
  assign o_occ   = occ_of(state_q);
`ifdef PIPE_STAGE_SKID_EN
  assign o_ready = ~rst & (state_q != ST_TWO);
`else
  assign o_ready = ~rst & ((state_q == ST_EMPTY) | i_ready);
`endif
  assign in_xfer_s  = i_valid & o_ready;
  assign out_xfer_s = o_valid & i_ready;
  // Any path to EMPTY (drain, flush, reset) parks the head control at its safe value.
  assign clr_main_s = (state_d == ST_EMPTY);

  // Next-state and slot load decode.
  always_comb begin
    state_d     = state_q;
    ld_main_s   = 1'b0;
    main_data_d = i_data;
    main_ctrl_d = i_ctrl;
`ifdef PIPE_STAGE_SKID_EN
    ld_skid_s   = 1'b0;
`endif
    if (rst | i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_d   = ST_ONE;
            ld_main_s = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s & out_xfer_s) begin
            state_d   = ST_ONE;
            ld_main_s = 1'b1;
          end else if (out_xfer_s) begin
            state_d = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_xfer_s) begin
            state_d   = ST_TWO;
            ld_skid_s = 1'b1;
`endif
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          if (out_xfer_s) begin
            state_d     = ST_ONE;
            ld_main_s   = 1'b1;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end else begin
            state_d = ST_TWO;
          end
`else
          state_d = ST_EMPTY;
`endif
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_stage_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_SAFE(CTRL_SAFE)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_main_s),
    .ld_i  (ld_main_s),
    .data_i(main_data_d),
    .ctrl_i(main_ctrl_d),
    .data_o(o_data),
    .ctrl_o(o_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_stage_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_SAFE(CTRL_SAFE)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr_i (i_flush),
    .ld_i  (ld_skid_s),
    .data_i(i_data),
    .ctrl_i(i_ctrl),
    .data_o(skid_data_q),
    .ctrl_o(skid_ctrl_q)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps plus random traffic,
// compared every cycle against a queue-based model of the held entries.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, i_valid, o_ready, o_valid, i_ready, i_flush;
  logic [DW-1:0] i_data, o_data;
  logic [CW-1:0] i_ctrl, o_ctrl;
  logic [1:0]    o_occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_ctrl(o_ctrl), .i_flush(i_flush), .o_occ(o_occ)
  );

  int             checks = 0;
  int             errors = 0;
  logic [39:0]    mq[$];
  logic [DW-1:0]  s_data;
  logic [CW-1:0]  s_ctrl;
  logic           s_valid, s_ready;
  logic [1:0]     s_occ;
  logic           last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, compare with model, update model at posedge.
  task automatic cycle(input logic v, input logic r, input logic f, input logic rs,
                       input logic [DW-1:0] d, input logic [CW-1:0] c, input bit chk);
    logic exp_ready, in_x, out_x;
    i_valid = v; i_ready = r; i_flush = f; rst = rs; i_data = d; i_ctrl = c;
    @(negedge clk);
    s_data = o_data; s_ctrl = o_ctrl; s_valid = o_valid; s_ready = o_ready; s_occ = o_occ;
    exp_ready = !rs && ((mq.size() < CAP) || (!SKID && r));
    if (chk) begin
      check("ready", s_ready, exp_ready);
      check("valid", s_valid, mq.size() > 0);
      check("occ", s_occ, mq.size());
      check("ctrl", s_ctrl, (mq.size() > 0) ? mq[0][39:32] : 8'h00);
      check("occ_range", s_occ <= CAP, 1'b1);
      if (mq.size() > 0) check("data", s_data, mq[0][31:0]);
    end
    in_x  = v && exp_ready;
    out_x = (mq.size() > 0) && r;
    last_acc = in_x && !rs && !f;
    @(posedge clk);
    if (rs || f) begin
      mq.delete();
    end else begin
      if (out_x) void'(mq.pop_front());
      if (in_x) mq.push_back({c, d});
    end
    #1;
  endtask

  initial begin
    int pushed;
    int cyc;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    i_data = 32'h0; i_ctrl = 8'h00;

    // Reset with live inputs; state is unknown before the first edge.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'h3C, 1'b0);
    check("rst_ready_first", s_ready, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'h3C, 1'b1);
    check("rst_data_zero", s_data, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("post_rst_ready", s_ready, 1'b1);

    // Streaming 1..8 back to back.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, DW'(i), 8'h01, 1'b1);
      if (i > 1) check("stream_data", s_data, DW'(i - 1));
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("stream_last", s_data, 32'd8);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);

    // Stall with a pending second entry.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5, 8'h81, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hB6, 8'h42, 1'b1);
    check("stall_hold", s_data, 32'hA5);
    check("stall_ctrl", s_ctrl, 8'h81);
    check("stall_occ", s_occ, 2'(CAP));
    check("stall_ready", s_ready, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hB6, 8'h42, 1'b1);
    check("release_a5", s_data, 32'hA5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("release_b6", s_data, 32'hB6);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("release_empty", s_valid, 1'b0);

    // Flush from the full state together with an offered input.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 8'h5A, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 8'h5B, 1'b1);
    check("preflush_occ", s_occ, 2'(CAP));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 8'h77, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("flush_valid", s_valid, 1'b0);
    check("flush_ctrl", s_ctrl, 8'h00);
    check("flush_occ", s_occ, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
      check("flush_no77", s_valid, 1'b0);
    end

    // Control visible only while the entry is valid.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h99, 8'hFF, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("safe_ff", s_ctrl, 8'hFF);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("safe_00", s_ctrl, 8'h00);

    // Random traffic against the model.
    pushed = 0;
    cyc = 0;
    while (pushed < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
            DW'($urandom), CW'($urandom_range(0, 255)), 1'b1);
      if (last_acc) pushed++;
      cyc++;
    end
    check("rand_entries", pushed, 1000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("rand_drained", s_valid, 1'b0);

    // Reset mid-operation discards held entries.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 8'h0F, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h6, 8'h0F, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    check("midrst_valid", s_valid, 1'b0);
    check("midrst_data", s_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. Successor to the fixed per-stage field registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one data bundle and one control bundle between adjacent stages with a valid/ready handshake, back-pressure (stall) and flush (bubble insertion).
- Control bits are forced to a safe value whenever the stage holds no valid instruction, so an invalid entry never asserts RegWrite, MemWrite or similar.

Parameters:
- DATA_W, 32: width of the data bundle (PC, operands, immediates, register addresses concatenated by the instantiating stage).
- CTRL_W, 8: width of the control bundle.
- CTRL_SAFE, {CTRL_W{1'b0}}: value driven on o_ctrl when o_valid=0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  upstream has an entry to offer.
- o_ready  out  1  this stage can accept an entry this cycle.
- i_data  in  DATA_W  upstream data bundle.
- i_ctrl  in  CTRL_W  upstream control bundle.
- o_valid  out  1  this stage presents a valid entry.
- i_ready  in  1  downstream accepts this cycle (0 = stall).
- o_data  out  DATA_W  data bundle presented downstream.
- o_ctrl  out  CTRL_W  control bundle presented downstream; equals CTRL_SAFE when o_valid=0.
- i_flush  in  1  discard all held entries (branch mispredict or exception).
- o_occ  out  2  number of held entries (0..2).

Behaviour:
- Transfers:
  - An input transfer occurs on a cycle where i_valid & o_ready.
  - An output transfer occurs on a cycle where o_valid & i_ready.
  - Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- Reset (rst=1 at a clock edge):
  - Next state: o_valid=0, o_data=0, o_ctrl=CTRL_SAFE, o_occ=0.
  - o_ready=0 while rst is high; all inputs are ignored during that cycle.
  - Reset asserted mid-operation discards every held entry.
- Flush:
  - i_flush=1 at an edge sets occupancy to 0 in the next cycle: o_valid=0, o_ctrl=CTRL_SAFE.
  - An input transfer in the same cycle is also discarded; flush wins.
  - o_data keeps its last value (don't-care).
  - Flush and rst together behave as reset.
- o_valid is high iff occupancy > 0.
- o_data and o_ctrl always come from the main (head) slot.
- Base mode (single slot, no macro):
  - States: EMPTY (occ=0) and FULL (occ=1).
  - o_ready = ~rst & (EMPTY | i_ready). This is a combinational path from i_ready.
  - EMPTY, input transfer -> FULL, slot loaded.
  - FULL, input & output transfer in the same cycle -> FULL, slot reloaded. Full throughput, zero bubbles.
  - FULL, output only -> EMPTY.
  - FULL, no transfer -> hold.
- Latency: 1 cycle from input transfer to o_valid, in both modes.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: adds a second (skid) slot, giving states EMPTY/ONE/TWO.
  - o_ready = ~rst & (state != TWO). It depends only on state, which breaks the i_ready->o_ready combinational path.
  - ONE, input & no output -> TWO; new entry goes to the skid slot.
  - ONE, input & output -> ONE; main slot reloaded.
  - ONE, output only -> EMPTY.
  - TWO, output -> ONE; main slot <= skid slot.
  - TWO never accepts input.
  - o_occ reports 2 in TWO.
  - Flush clears both slots.
- Undefined: base mode; o_occ never exceeds 1.

Decomposition:
- Package pipe_stage_pkg:
  - State enum typedef (EMPTY, ONE, TWO).
  - OCC_W=2 constant.
  - Default CTRL_SAFE helper constant.
- Sub-module pipe_stage_slot:
  - One DATA_W+CTRL_W register with load enable and synchronous clear of the ctrl field to CTRL_SAFE.
  - Instantiated once in base mode, twice with PIPE_STAGE_SKID_EN.

Test Plan:
- Reset: hold rst 2 cycles with i_valid=1, i_data=32'hDEADBEEF -> o_valid=0, o_ctrl=8'h00, o_occ=0 and o_ready=0 throughout; cycle after release: o_ready=1.
- Streaming: i_ready=1, send data 1..8 on back-to-back cycles -> o_data emits 1..8 on consecutive cycles, each 1 cycle after its input, with no bubbles.
- Stall: load 32'hA5 with ctrl 8'h81, then hold i_ready=0 for 3 cycles while i_valid=1 with 32'hB6.
  - Base mode: o_ready=0 and o_data=32'hA5 stable.
  - Skid mode: 32'hB6 accepted into the skid slot, o_occ=2, o_ready=0.
  - Releasing i_ready then emits A5 followed by B6.
- Flush: in state FULL/TWO, pulse i_flush together with an input transfer of 32'h77 -> next cycle o_valid=0, o_ctrl=8'h00, o_occ=0; 32'h77 never appears at the output.
- Safe control: with CTRL_SAFE=8'h00, accept one entry with ctrl 8'hFF and drain it -> o_ctrl=8'hFF for exactly the one valid cycle, then 8'h00.
- Random: random i_valid/i_ready at 50%, 1000 entries, with a scoreboard -> output order equals input order, no loss or duplication, o_occ always 0..2 (0..1 in base mode).
